// File: rtl/ex_pkg.sv
// Shared opcode constants, FSM state type and helpers for the execute stage.
package ex_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_LUI   = 5'd11;
    localparam logic [4:0] OP_MUL   = 5'd16;
    localparam logic [4:0] OP_MULHU = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ex_state_e;

    function automatic logic is_multi(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative shift-add multiplier (one partial product per cycle) with start/done handshake.
// Compiled only when EX_STAGE_MULDIV_EN is defined.
`ifdef EX_STAGE_MULDIV_EN
module ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] lo_o,
    output logic [XLEN-1:0] hi_o
);
    localparam int unsigned CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] mcand_q, hi_q, lo_q, hi_d, lo_d;
    logic [CW-1:0]   cnt_q;
    logic            run_q;
    logic [XLEN:0]   sum;

    always_comb begin
        sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
    end

    // done marks the cycle whose closing edge completes the final partial product
    assign done_o = run_q && (cnt_q == CW'(XLEN - 1));
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (abort_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            mcand_q <= a_i;
            hi_q    <= '0;
            lo_q    <= b_i;
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done_o) run_q <= 1'b0;
        end
    end
endmodule
`endif

// File: rtl/ex_stage_fwd.sv
// Execute stage with prioritised operand forwarding and a registered ALU result.
// Optional iterative MUL/MULHU via FSM + ex_muldiv when EX_STAGE_MULDIV_EN is defined.
module ex_stage_fwd
    import ex_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_ir,
    input  logic [4:0]           in_op,
    input  logic                 in_wb,
    input  logic [4:0]           in_rs_addr,
    input  logic [4:0]           in_rt_addr,
    input  logic [4:0]           in_rd_addr,
    input  logic [XLEN-1:0]      in_a,
    input  logic [XLEN-1:0]      in_b,
    input  logic                 in_b_is_rt,
    input  logic [XLEN-1:0]      in_sw,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [5*NFWD-1:0]    fwd_addr,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    output logic                 out_valid,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_ir,
    output logic [4:0]           out_rd_addr,
    output logic                 out_wb,
    output logic [XLEN-1:0]      out_result,
    output logic                 out_flag,
    output logic [XLEN-1:0]      out_swdata,
    output logic                 busy
);
    localparam logic [XLEN-1:0] RST_RESULT = XLEN'({((XLEN + 7) / 8){8'hCC}});

    logic [XLEN-1:0] rs_val, rt_val, op_a, op_b, alu_res;
    logic            rs_hit, rt_hit;
    logic [4:0]      shamt;

    logic            out_valid_q, out_wb_q;
    logic [31:0]     out_pc_q, out_ir_q;
    logic [4:0]      out_rd_q;
    logic [XLEN-1:0] out_result_q, out_sw_q;

    always_comb begin
        rs_val = in_a;
        rs_hit = 1'b0;
        rt_val = in_sw;
        rt_hit = 1'b0;
        for (int unsigned i = 0; i < NFWD; i++) begin
            if (!rs_hit && fwd_valid[i] && (in_rs_addr != 5'd0) && (fwd_addr[5*i +: 5] == in_rs_addr)) begin
                rs_val = fwd_data[XLEN*i +: XLEN];
                rs_hit = 1'b1;
            end
            if (!rt_hit && fwd_valid[i] && (in_rt_addr != 5'd0) && (fwd_addr[5*i +: 5] == in_rt_addr)) begin
                rt_val = fwd_data[XLEN*i +: XLEN];
                rt_hit = 1'b1;
            end
        end
    end

    assign op_a  = rs_val;
    assign op_b  = (in_b_is_rt && rt_hit) ? rt_val : in_b;
    assign shamt = op_b[4:0] & 5'(XLEN - 1);

    always_comb begin
        alu_res = '0;
        case (in_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: alu_res = XLEN'(op_a < op_b);
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
            OP_LUI:  alu_res = op_b << 16;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_STAGE_MULDIV_EN
    ex_state_e       state_q;
    logic            mul_start, mul_done, pend_hi_q, pend_wb_q;
    logic [31:0]     pend_pc_q, pend_ir_q;
    logic [4:0]      pend_rd_q;
    logic [XLEN-1:0] pend_sw_q, prod_lo, prod_hi;

    assign mul_start = (state_q == ST_IDLE) && in_valid && !stall && !flush && is_multi(in_op);
    assign busy      = (state_q != ST_IDLE);

    ex_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .abort_i (flush),
        .a_i     (op_a),
        .b_i     (op_b),
        .done_o  (mul_done),
        .lo_o    (prod_lo),
        .hi_o    (prod_hi)
    );
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_wb_q     <= 1'b0;
            out_pc_q     <= '0;
            out_ir_q     <= '0;
            out_rd_q     <= '0;
            out_result_q <= RST_RESULT;
            out_sw_q     <= '0;
`ifdef EX_STAGE_MULDIV_EN
            state_q   <= ST_IDLE;
            pend_hi_q <= 1'b0;
            pend_wb_q <= 1'b0;
            pend_pc_q <= '0;
            pend_ir_q <= '0;
            pend_rd_q <= '0;
            pend_sw_q <= '0;
`endif
        end else if (flush) begin
            out_valid_q <= 1'b0;
            out_wb_q    <= 1'b0;
`ifdef EX_STAGE_MULDIV_EN
            state_q <= ST_IDLE;
`endif
        end else begin
`ifdef EX_STAGE_MULDIV_EN
            // FSM states take precedence; the trailing else falls into the single-cycle path
            if (state_q == ST_RUN) begin
                if (mul_done) state_q <= ST_DONE;
            end else if (state_q == ST_DONE) begin
                if (!stall) begin
                    out_valid_q  <= 1'b1;
                    out_wb_q     <= pend_wb_q;
                    out_pc_q     <= pend_pc_q;
                    out_ir_q     <= pend_ir_q;
                    out_rd_q     <= pend_rd_q;
                    out_sw_q     <= pend_sw_q;
                    out_result_q <= pend_hi_q ? prod_hi : prod_lo;
                    state_q      <= ST_IDLE;
                end
            end else if (mul_start) begin
                state_q     <= ST_RUN;
                pend_hi_q   <= (in_op == OP_MULHU);
                pend_wb_q   <= in_wb;
                pend_pc_q   <= in_pc;
                pend_ir_q   <= in_ir;
                pend_rd_q   <= in_rd_addr;
                pend_sw_q   <= rt_val;
                out_valid_q <= 1'b0;
                out_wb_q    <= 1'b0;
            end else
`endif
            if (!stall) begin
                if (in_valid) begin
                    out_valid_q  <= 1'b1;
                    out_wb_q     <= in_wb;
                    out_pc_q     <= in_pc;
                    out_ir_q     <= in_ir;
                    out_rd_q     <= in_rd_addr;
                    out_result_q <= alu_res;
                    out_sw_q     <= rt_val;
                end else begin
                    out_valid_q <= 1'b0;
                    out_wb_q    <= 1'b0;
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_wb      = out_wb_q;
    assign out_pc      = out_pc_q;
    assign out_ir      = out_ir_q;
    assign out_rd_addr = out_rd_q;
    assign out_result  = out_result_q;
    assign out_swdata  = out_sw_q;
    assign out_flag    = (out_result_q == '0);

endmodule

// File: tb/tb_ex_stage_fwd.sv
// Directed and randomized bench for ex_stage_fwd against a behavioural model.
module tb_ex_stage_fwd;
    localparam int XLEN = 32;
    localparam int NFWD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid, in_wb, in_b_is_rt, stall, flush;
    logic [31:0] in_pc, in_ir, in_a, in_b, in_sw;
    logic [4:0] in_op, in_rs_addr, in_rt_addr, in_rd_addr;
    logic [NFWD-1:0] fwd_valid;
    logic [5*NFWD-1:0] fwd_addr;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic [4:0] fa [NFWD];
    logic [31:0] fd [NFWD];

    logic out_valid, out_wb, out_flag, busy;
    logic [31:0] out_pc, out_ir, out_result, out_swdata;
    logic [4:0] out_rd_addr;

    logic e_valid, e_wb;
    logic [31:0] e_pc, e_ir, e_res, e_sw;
    logic [4:0] e_rd;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NFWD; i++) begin
            fwd_addr[5*i +: 5]  = fa[i];
            fwd_data[32*i +: 32] = fd[i];
        end
    end

    ex_stage_fwd #(.XLEN(XLEN), .NFWD(NFWD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc), .in_ir(in_ir),
        .in_op(in_op), .in_wb(in_wb), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_rd_addr(in_rd_addr), .in_a(in_a), .in_b(in_b), .in_b_is_rt(in_b_is_rt),
        .in_sw(in_sw), .stall(stall), .flush(flush), .fwd_valid(fwd_valid),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .out_valid(out_valid), .out_pc(out_pc),
        .out_ir(out_ir), .out_rd_addr(out_rd_addr), .out_wb(out_wb), .out_result(out_result),
        .out_flag(out_flag), .out_swdata(out_swdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Later (lower-index) matches overwrite earlier ones, so index 0 wins.
    function automatic logic [31:0] pick(input logic [4:0] addr, input logic [31:0] dflt);
        logic [31:0] v = dflt;
        if (addr != 5'd0)
            for (int i = NFWD - 1; i >= 0; i--)
                if (fwd_valid[i] && fa[i] == addr) v = fd[i];
        return v;
    endfunction

    function automatic logic [31:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh = b % 32;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return ~(a | b);
            5'd6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5'd7:  return (a < b) ? 32'd1 : 32'd0;
            5'd8:  return 32'(longint'(a) * (longint'(1) << sh));
            5'd9:  return a / (32'd1 << sh);
            5'd10: return 32'(int'(a) >>> sh);
            5'd11: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outs();
        chk("valid", out_valid, e_valid);
        chk("wb", out_wb, e_wb);
        chk("pc", out_pc, e_pc);
        chk("ir", out_ir, e_ir);
        chk("rd", out_rd_addr, e_rd);
        chk("result", out_result, e_res);
        chk("flag", out_flag, e_res == 0);
        chk("swdata", out_swdata, e_sw);
        chk("busy", busy, 1'b0);
    endtask

    task automatic reset_model();
        e_valid = 0; e_wb = 0; e_pc = 0; e_ir = 0; e_rd = 0; e_res = 32'hCCCCCCCC; e_sw = 0;
    endtask

    task automatic cycle();
        logic [31:0] a, b, sw;
        a  = pick(in_rs_addr, in_a);
        b  = in_b_is_rt ? pick(in_rt_addr, in_b) : in_b;
        sw = pick(in_rt_addr, in_sw);
        if (flush) begin
            e_valid = 0; e_wb = 0;
        end else if (!stall) begin
            if (in_valid) begin
                e_valid = 1; e_wb = in_wb; e_pc = in_pc; e_ir = in_ir; e_rd = in_rd_addr;
                e_res = alu(in_op, a, b); e_sw = sw;
            end else begin
                e_valid = 0; e_wb = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outs();
    endtask

    initial begin
        logic [4:0] ops [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                 5'd8, 5'd9, 5'd10, 5'd11, 5'd16, 5'd17};
        int nops;
        int n;
        logic seen;
`ifdef EX_STAGE_MULDIV_EN
        nops = 12;
`else
        nops = 14;
`endif
        in_valid = 0; in_wb = 0; in_b_is_rt = 0; stall = 0; flush = 0;
        in_pc = 0; in_ir = 0; in_a = 0; in_b = 0; in_sw = 0;
        in_op = 0; in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
        fwd_valid = 0; fa[0] = 0; fa[1] = 0; fd[0] = 0; fd[1] = 0;
        reset_model();
        #12;
        check_outs();
        rst_n = 1;

        // ADD with rs forwarded from source 0
        in_valid = 1; in_op = 0; in_a = 5; in_b = 7; in_rs_addr = 3; in_rt_addr = 4;
        in_rd_addr = 6; in_wb = 1; in_pc = 32'h100; in_ir = 32'h1234; in_sw = 32'h77;
        fwd_valid = 2'b01; fa[0] = 3; fd[0] = 100;
        cycle();
        chk("add_fwd_result", out_result, 32'd107);
        chk("add_fwd_flag", out_flag, 1'b0);

        // both sources match rs: index 0 wins
        in_op = 1; in_b = 1; fwd_valid = 2'b11; fa[0] = 3; fd[0] = 1; fa[1] = 3; fd[1] = 2;
        in_pc = 32'h104;
        cycle();
        chk("prio_result", out_result, 32'd0);
        chk("prio_flag", out_flag, 1'b1);

        // address 0 never forwards
        in_op = 0; in_rs_addr = 0; in_a = 0; in_b = 3; fwd_valid = 2'b01; fa[0] = 0; fd[0] = 9;
        cycle();
        chk("zero_addr_result", out_result, 32'd3);

        // rt forwarding into b and store data
        in_a = 1; in_rs_addr = 7; in_b_is_rt = 1; in_rt_addr = 5; in_b = 11; in_sw = 22;
        fwd_valid = 2'b10; fa[0] = 5; fd[0] = 30; fa[1] = 5; fd[1] = 40;
        cycle();
        chk("rt_fwd_result", out_result, 32'd41);
        chk("rt_fwd_sw", out_swdata, 32'd40);

        // immediate b, store data still forwarded
        in_b_is_rt = 0; in_pc = 32'h108;
        cycle();
        chk("imm_result", out_result, 32'd12);
        chk("imm_sw", out_swdata, 32'd40);

        // stall holds outputs for 3 cycles
        stall = 1; in_a = 1000; in_pc = 32'h200;
        repeat (3) cycle();
        chk("stall_hold_result", out_result, 32'd12);
        chk("stall_hold_pc", out_pc, 32'h108);

        // flush overrides stall
        flush = 1;
        cycle();
        chk("flush_valid", out_valid, 1'b0);
        flush = 0; stall = 0; in_valid = 0;
        cycle();
        chk("bubble_valid", out_valid, 1'b0);

        // shift masking and signed compare boundaries
        in_valid = 1; fwd_valid = 0; in_op = 10; in_a = 32'h80000000; in_b = 33;
        cycle();
        chk("sra_mask", out_result, 32'hC0000000);
        in_op = 6; in_b = 1;
        cycle();
        chk("slt_neg", out_result, 32'd1);
        in_op = 7;
        cycle();
        chk("sltu_big", out_result, 32'd0);
`ifndef EX_STAGE_MULDIV_EN
        in_op = 16; in_a = 32'hFFFFFFFF; in_b = 2;
        cycle();
        chk("mul_disabled_result", out_result, 32'd0);
        chk("mul_disabled_valid", out_valid, 1'b1);
`endif

        for (int k = 0; k < 400; k++) begin
            in_valid   = ($urandom_range(0, 9) != 0);
            in_op      = ops[$urandom_range(0, nops - 1)];
            in_a       = $urandom;
            in_b       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            in_b_is_rt = 1'($urandom_range(0, 1));
            in_rs_addr = 5'($urandom_range(0, 3));
            in_rt_addr = 5'($urandom_range(0, 3));
            in_rd_addr = 5'($urandom_range(0, 31));
            in_wb      = 1'($urandom_range(0, 1));
            in_pc      = $urandom;
            in_ir      = $urandom;
            in_sw      = $urandom;
            fwd_valid  = 2'($urandom_range(0, 3));
            fa[0] = 5'($urandom_range(0, 3)); fa[1] = 5'($urandom_range(0, 3));
            fd[0] = $urandom; fd[1] = $urandom;
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            cycle();
        end
        stall = 0; flush = 0; fwd_valid = 0;

`ifdef EX_STAGE_MULDIV_EN
        for (int m = 0; m < 2; m++) begin
            in_valid = 1; in_op = (m == 0) ? 5'd16 : 5'd17; in_a = 32'hFFFFFFFF; in_b = 2;
            in_b_is_rt = 0; in_pc = 32'h300 + m; in_wb = 1;
            @(posedge clk);
            #1;
            in_valid = 0;
            chk("mul_busy_start", busy, 1'b1);
            chk("mul_valid_low", out_valid, 1'b0);
            n = 0;
            seen = 0;
            while (busy && n < 100) begin
                @(posedge clk);
                #1;
                n++;
                if (busy && out_valid) seen = 1;
            end
            chk("mul_busy_cycles", n, 33);
            chk("mul_valid_in_run", seen, 1'b0);
            chk("mul_result", out_result, (m == 0) ? 32'hFFFFFFFE : 32'd1);
            chk("mul_valid", out_valid, 1'b1);
            chk("mul_pc", out_pc, 32'h300 + m);
        end
`endif

        // reset in the middle of a MUL
        in_valid = 1; in_op = 16; in_a = 32'hFFFFFFFF; in_b = 2; in_b_is_rt = 0;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_result", out_result, 32'hCCCCCCCC);
        #2;
        rst_n = 1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("rst_no_result", seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_stage_fwd.md
EX_STAGE_FWD -- requirements
Module: ex_stage_fwd

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter NFWD, default 2: number of forwarding sources; index 0 = youngest, highest priority.
REQ-003 SHALL have clock clk; reset rst_n, asynchronous, active-low.
REQ-004 SHALL have ports: clk in 1, clock; rst_n in 1, reset.
REQ-005 SHALL have ports: in_valid in 1, instruction present; in_pc in 32; in_ir in 32; in_op in 5, ALU opcode; in_wb in 1, instruction writes rd.
REQ-006 SHALL have ports: in_rs_addr in 5; in_rt_addr in 5; in_rd_addr in 5; in_a in XLEN, rs operand; in_b in XLEN, rt operand or immediate; in_b_is_rt in 1, in_b is register sourced; in_sw in XLEN, store data (rt).
REQ-007 SHALL have ports: stall in 1, hold stage; flush in 1, kill stage contents.
REQ-008 SHALL have ports: fwd_valid in NFWD; fwd_addr in 5*NFWD; fwd_data in XLEN*NFWD.
REQ-009 SHALL have ports: out_valid out 1; out_pc out 32; out_ir out 32; out_rd_addr out 5; out_wb out 1; out_result out XLEN; out_flag out 1, result==0; out_swdata out XLEN; busy out 1, multi-cycle op in progress, upstream holds.

Function
REQ-010 SHALL resolve operands combinationally: for rs, and for rt when in_b_is_rt, lowest index i with fwd_valid[i] and fwd_addr[i]==addr supplies data, else in_a/in_b.
REQ-011 SHALL forward in_sw from rt with the same priority regardless of in_b_is_rt.
REQ-012 SHALL never forward for address 0; operand is the input value.
REQ-013 SHALL implement ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL, SRA (shift amount = b[4:0] masked to log2(XLEN)), LUI (b<<16); arithmetic wraps modulo 2^XLEN, no overflow trap.
REQ-014 SHALL register single-cycle results: input accepted at edge N appears on out_* after edge N+1 (latency 1).
REQ-015 SHALL accept input when in_valid && !stall && !busy && !flush.
REQ-016 SHALL hold all out_* when stall=1 and flush=0.
REQ-017 SHALL, on flush, set out_valid=0 and out_wb=0 at next edge and return FSM to IDLE; flush overrides stall and busy.
REQ-018 SHALL present out_valid=0 and out_wb=0 (bubble) when not stalled and no instruction accepted.
REQ-019 SHALL run FSM IDLE -> RUN (multi-cycle op accepted) -> DONE (count reaches XLEN) -> IDLE (output written, unless stall, then stay DONE).
REQ-020 SHALL assert busy in RUN and DONE; busy=0 in IDLE.
REQ-021 SHALL capture forwarded operands into internal registers on entry to RUN; later forwarding changes do not affect the op.
REQ-022 SHALL hold out_valid=0 during RUN; multi-cycle result appears XLEN+1 cycles after acceptance when unstalled.
REQ-023 SHALL compute out_flag from the registered result in the same cycle it is presented.

Reset
REQ-024 SHALL on rst_n=0 set: out_valid=0, out_wb=0, out_pc=0, out_ir=0, out_rd_addr=0, out_result=0xCCCCCCCC truncated/replicated to XLEN, out_flag=0, out_swdata=0, FSM=IDLE, counter=0, busy=0.
REQ-025 SHALL abort any multi-cycle op on reset mid-operation; no result emitted.

Configuration
REQ-026 SHALL with EX_STAGE_MULDIV_EN defined implement MUL (low XLEN) and MULHU (high XLEN) as shift-add over XLEN cycles via the FSM.
REQ-027 SHALL without EX_STAGE_MULDIV_EN treat MUL/MULHU as single-cycle ops with result 0; FSM, counter and busy logic absent, busy tied 0.

Structure
REQ-028 SHALL place opcode constants (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11, MUL=16, MULHU=17) and FSM state encoding in package ex_pkg.
REQ-029 SHALL instantiate one sub-module ex_muldiv (iterative multiplier, start/done handshake), only under EX_STAGE_MULDIV_EN.

Verification
REQ-030 SHALL cover: ADD a=5,b=7, fwd_valid[0]=1 addr=rs data=100 -> out_result=107 after 1 cycle, out_flag=0.
REQ-031 SHALL cover: both fwd sources match rs (data 1 and 2) -> index 0 wins, SUB b=1 -> result 0, out_flag=1.
REQ-032 SHALL cover: rs_addr=0 with fwd_addr[0]=0 valid data 9, in_a=0 -> forwarding ignored, ADD b=3 -> 3.
REQ-033 SHALL cover: stall 3 cycles after a result -> out_* unchanged; flush with stall -> out_valid=0 next cycle.
REQ-034 SHALL cover (MULDIV_EN): MUL 0xFFFFFFFF*2 -> busy for 33 cycles, out_result=0xFFFFFFFE; MULHU same -> 1.
REQ-035 SHALL cover: rst_n low mid-MUL -> busy=0, out_valid=0, out_result=0xCCCCCCCC.
